// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART transmit framer.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_EVEN  = 3'b001,
    PAR_ODD   = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Effective word width: requested width forced into [MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
    if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (int'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for the low n bits of a data word.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9
) (
  input  logic [MAX_DATA_BITS-1:0] data,
  input  logic [3:0]               n,
  input  logic [2:0]               mode,
  output logic                     parity,
  output logic                     enable
);

  logic xor_bits;

  always_comb begin
    xor_bits = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < int'(n)) xor_bits = xor_bits ^ data[i];
    end

    parity = 1'b0;
    enable = 1'b0;
    case (mode)
      PAR_EVEN:  begin parity = xor_bits;  enable = 1'b1; end
      PAR_ODD:   begin parity = ~xor_bits; enable = 1'b1; end
      PAR_MARK:  begin parity = 1'b1;      enable = 1'b1; end
      PAR_SPACE: begin parity = 1'b0;      enable = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 5..MAX data bits LSB-first, optional parity, 1/2 stop bits.
//
// state  | meaning
// IDLE   | line high, ready for a word
// SYNC   | word latched, waiting for the next bit_tick to align the start bit
// START  | start bit (low)
// DATA   | data bit idx_q
// PARITY | parity bit
// STOP   | stop bit(s), stop_cnt_q counts the second one
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               data_bits,
  input  logic [2:0]               parity_mode,
  input  logic                     stop_two,
  input  logic                     bit_tick,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IDX_W = $clog2(MAX_DATA_BITS);

  tx_state_t          state, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic               frame_done_q, done_d;

  logic [MAX_DATA_BITS-1:0] data_q;
  logic [3:0]               n_q;
  logic                     par_bit_q, par_en_q, stop_two_q;

  logic [3:0] n_in;
  logic       par_bit, par_en;
  logic       accept;
  logic       last_idx;

  assign n_in     = clamp_bits(data_bits, MAX_DATA_BITS);
  assign tx_ready = (state == ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign last_idx = (idx_q == IDX_W'(n_q - 4'd1));

  uart_parity_gen #(
    .MAX_DATA_BITS(MAX_DATA_BITS)
  ) u_parity (
    .data  (tx_data),
    .n     (n_in),
    .mode  (parity_mode),
    .parity(par_bit),
    .enable(par_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx_q        <= '0;
      stop_cnt_q   <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      data_q       <= '0;
      n_q          <= '0;
      par_bit_q    <= 1'b0;
      par_en_q     <= 1'b0;
      stop_two_q   <= 1'b0;
    end else begin
      state        <= state_d;
      idx_q        <= idx_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      frame_done_q <= done_d;
      if (accept) begin
        data_q     <= tx_data;
        n_q        <= n_in;
        par_bit_q  <= par_bit;
        par_en_q   <= par_en;
        stop_two_q <= stop_two;
      end
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state)
      ST_IDLE:  if (accept) state_d = ST_SYNC;
      ST_SYNC:  if (bit_tick) state_d = ST_START;
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (last_idx) begin
            idx_d      = '0;
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q || !stop_two_q) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered, so it follows the state being entered
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[idx_d];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule
